// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, default bit timing
// and the bit-counter width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int UART_BIT_CLKS_DEFAULT = 174;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset level so idle-high and idle-low lines both start quiet.
module uart_sync
    import uart_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit 2-of-3 majority sampling, start-bit validation,
// and a one-entry valid/ready holding register with framing/overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_CLKS = UART_BIT_CLKS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = cnt_width(BIT_CLKS);
    localparam int H  = BIT_CLKS / 2;
    localparam logic [CW-1:0] CNT_PRE  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);

    logic rxs;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (rx_in),
        .q     (rxs)
    );

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          s0_q, s0_d, s1_q, s1_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;

    logic at_dec, at_wrap, vote, deliver;

    assign at_dec  = (cnt_q == CNT_DEC);
    assign at_wrap = (cnt_q == CNT_LAST);
    // Third vote is the live sample at the decision count.
    assign vote    = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        deliver = 1'b0;
        fe_d    = 1'b0;

        if (state_q != ST_IDLE && state_q != ST_WAIT_IDLE) begin
            cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_PRE) s0_d = rxs;
            if (cnt_q == CNT_MID) s1_d = rxs;
        end

        case (state_q)
            ST_IDLE: begin
                // The detection cycle itself is count 0 of the start bit.
                cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = CW'(1);
                end
            end
            ST_START: begin
                if (at_dec && vote) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (at_wrap) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (at_dec) shift_d = {vote, shift_q[7:1]};
                if (at_wrap) begin
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                // Leave early so a back-to-back start edge is not missed.
                if (at_dec) begin
                    cnt_d = '0;
                    if (vote) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ov_d    = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame timing, false start, framing error,
// overrun/handshake, glitch rejection and asynchronous reset.
module tb_uart_rx;

    localparam int B = 174;
    localparam int H = B / 2;
    // Drive cycle of the start edge to rx_valid rise: 2 (sync) + 9*B + H + 2.
    localparam int LAT = 9 * B + H + 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.BIT_CLKS(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int rise_cnt, rise_cyc, valid_len, fe_cnt, fe_cyc, ov_cnt;
    int busy_rise_cyc, busy_fall_cyc;
    logic [7:0] rise_data;
    logic valid_prev = 1'b0;
    logic busy_prev  = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && !valid_prev) begin
            rise_cnt++;
            rise_cyc  = cyc;
            rise_data = rx_data;
        end
        if (rx_valid) valid_len++;
        valid_prev = rx_valid;
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (overrun) ov_cnt++;
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        rise_cnt      = 0;
        rise_cyc      = -1;
        valid_len     = 0;
        fe_cnt        = 0;
        fe_cyc        = -1;
        ov_cnt        = 0;
        busy_rise_cyc = -1;
        busy_fall_cyc = -1;
        rise_data     = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; each frame bit lasts exactly B cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int gl_bit, input int gl_off, output int fall);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        fall = cyc;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < B; c++) begin
                rx_in = (i == gl_bit && c == gl_off) ? 1'b0 : bits[i];
                @(posedge clk);
                #1;
            end
        end
        $display("frame sent: byte=%02h stop=%0b start_cyc=%0d", b, stop_bit, fall);
    endtask

    int f0, f1;

    initial begin
        reset    = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        clear_mon();
        #3;
        check("rst_data",  32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_fe",    32'(frame_err), 0);
        check("rst_ov",    32'(overrun), 0);
        check("rst_busy",  32'(busy), 0);
        idle(3);
        reset = 1'b1;
        idle(5);

        // 0x55 with consumer always ready
        rx_ready = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b1, -1, 0, f0);
        idle(20);
        check("t1_rises",    32'(rise_cnt), 1);
        check("t1_latency",  32'(rise_cyc - f0), 32'(LAT));
        check("t1_data",     32'(rise_data), 32'h55);
        check("t1_vlen",     32'(valid_len), 1);
        check("t1_busyrise", 32'(busy_rise_cyc - f0), 3);
        check("t1_busyfall", 32'(busy_fall_cyc - f0), 32'(LAT));
        check("t1_fe",       32'(fe_cnt), 0);
        check("t1_ov",       32'(ov_cnt), 0);

        // long low then high: bit 0 sampled high mid-bit
        clear_mon();
        f0 = cyc;
        rx_in = 1'b0;
        idle(200);
        rx_in = 1'b1;
        idle(10 * B);
        $display("long low pulse sent: start_cyc=%0d", f0);
        check("t2_rises",   32'(rise_cnt), 1);
        check("t2_data",    32'(rise_data), 32'hFF);
        check("t2_latency", 32'(rise_cyc - f0), 32'(LAT));
        check("t2_fe",      32'(fe_cnt), 0);

        // 40-cycle pulse is a false start
        clear_mon();
        f0 = cyc;
        rx_in = 1'b0;
        idle(40);
        rx_in = 1'b1;
        idle(300);
        $display("short pulse sent: start_cyc=%0d", f0);
        check("t3_rises",    32'(rise_cnt), 0);
        check("t3_fe",       32'(fe_cnt), 0);
        check("t3_busyrise", 32'(busy_rise_cyc - f0), 3);
        check("t3_busyfall", 32'(busy_fall_cyc - f0), 32'(H + 4));

        // framing error followed by a break
        clear_mon();
        send_frame(8'hA3, 1'b0, -1, 0, f0);
        idle(500);
        check("t4_busy_brk", 32'(busy), 1);
        rx_in = 1'b1;
        idle(6);
        check("t4_busy_end", 32'(busy), 0);
        check("t4_fe",       32'(fe_cnt), 1);
        check("t4_fe_time",  32'(fe_cyc - f0), 32'(LAT));
        check("t4_rises",    32'(rise_cnt), 0);

        // overrun: consumer not ready for two frames
        rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h12, 1'b1, -1, 0, f0);
        idle(B);
        send_frame(8'h34, 1'b1, -1, 0, f1);
        idle(20);
        check("t5_ov",    32'(ov_cnt), 1);
        check("t5_data",  32'(rx_data), 32'h12);
        check("t5_valid", 32'(rx_valid), 1);
        check("t5_rises", 32'(rise_cnt), 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("t5_drain", 32'(rx_valid), 0);

        // ready pulsed exactly on the second delivery cycle
        clear_mon();
        send_frame(8'h12, 1'b1, -1, 0, f0);
        idle(B);
        fork
            send_frame(8'h34, 1'b1, -1, 0, f1);
            begin
                idle(LAT - 1);
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
            end
        join
        idle(20);
        check("t5b_data",  32'(rx_data), 32'h34);
        check("t5b_valid", 32'(rx_valid), 1);
        check("t5b_ov",    32'(ov_cnt), 0);
        rx_ready = 1'b1;
        idle(2);

        // one-cycle glitch at mid-bit of data bit 0 (a '1')
        clear_mon();
        send_frame(8'hB5, 1'b1, 1, H, f0);
        idle(20);
        check("t6_data",  32'(rise_data), 32'hB5);
        check("t6_rises", 32'(rise_cnt), 1);

        // asynchronous reset in the middle of DATA
        rx_in = 1'b0;
        idle(B);
        rx_in = 1'b1;
        idle(200);
        check("t7_busy_pre", 32'(busy), 1);
        reset = 1'b0;
        #2;
        check("t7_rst_data", 32'(rx_data), 32'h00);
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_val",  32'(rx_valid), 0);
        idle(3);
        reset = 1'b1;
        idle(2 * B);
        clear_mon();
        send_frame(8'hC3, 1'b1, -1, 0, f0);
        idle(20);
        check("t7_data",    32'(rise_data), 32'hC3);
        check("t7_rises",   32'(rise_cnt), 1);
        check("t7_latency", 32'(rise_cyc - f0), 32'(LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
